// File: rtl/tempsens_avg.sv
// tempsens_avg: measurement sequencer and averager for tempsens_ctrl.
//
// The block restarts the controller through its active-high reset and collects
// 2**N_AVG_LOG2 raw delay-line counts. It then presents the truncated mean on a
// valid/ready interface. It supports single-shot and continuous modes.
//
// Optional feature macro: TEMPSENS_AVG_TIMEOUT_EN
//   defined   - each conversion is bounded by a TIMEOUT_W-bit cycle counter. A
//               timed-out sample counts as all-ones and sets the sticky o_timeout.
//   undefined - CONV waits indefinitely for i_ts_done and o_timeout is tied to 0.

module tempsens_avg #(
  parameter int unsigned N_TEMP     = 20,
  parameter int unsigned N_AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT_W  = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  output logic              o_ts_reset,
  input  logic [N_TEMP-1:0] i_ts_res,
  input  logic              i_ts_done,
  output logic              o_busy,
  output logic [N_TEMP-1:0] o_avg,
  output logic              o_avg_valid,
  input  logic              i_avg_ready,
  output logic              o_timeout
);

  // The sum of 2**N_AVG_LOG2 full-scale samples fits exactly, so it cannot overflow.
  localparam int unsigned AccW = N_TEMP + N_AVG_LOG2;

  // Elaboration-time sanity checks on the configuration.
  if (N_AVG_LOG2 < 1 || N_AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("tempsens_avg: N_AVG_LOG2 must be in 1..4");
  end
  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("tempsens_avg: TIMEOUT_W must be at least 1");
  end
  if (N_TEMP < 1) begin : g_bad_n_temp
    $error("tempsens_avg: N_TEMP must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRst,
    StConv,
    StOut
  } state_e;

  state_e                  state_q;
  logic [AccW-1:0]         acc_q;
  logic [N_AVG_LOG2-1:0]   cnt_q;
  logic                    ts_reset_q;
  logic                    busy_q;
  logic [N_TEMP-1:0]       avg_q;
  logic                    avg_valid_q;

  logic                    tmo_hit;
  logic                    take;
  logic                    last;
  logic [N_TEMP-1:0]       sample;
  logic [AccW-1:0]         acc_sum;

  // Decide whether a sample is taken this cycle and what it contributes.
  always_comb begin
    take    = 1'b0;
    sample  = '0;
    acc_sum = '0;
    last    = 1'b0;
    take    = (state_q == StConv) && (i_ts_done || tmo_hit);
    // A genuine done always beats the timeout, even when both land together.
    sample  = i_ts_done ? i_ts_res : {N_TEMP{1'b1}};
    acc_sum = acc_q + {{N_AVG_LOG2{1'b0}}, sample};
    // The sample index wraps after the final sample. It is cleared before reuse.
    last    = &cnt_q;
  end

  // Main sequencer. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ts_reset_q  <= 1'b1;
      busy_q      <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q <= StRst;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end

        // One cycle of controller reset before every conversion.
        StRst: begin
          state_q    <= StConv;
          ts_reset_q <= 1'b0;
        end

        StConv: begin
          if (take) begin
            acc_q      <= acc_sum;
            cnt_q      <= cnt_q + N_AVG_LOG2'(1);
            ts_reset_q <= 1'b1;
            if (last) begin
              state_q     <= StOut;
              avg_q       <= acc_sum[AccW-1:N_AVG_LOG2];
              avg_valid_q <= 1'b1;
            end else begin
              state_q <= StRst;
            end
          end
        end

        StOut: begin
          if (i_avg_ready) begin
            avg_valid_q <= 1'b0;
            if (i_continuous) begin
              state_q <= StRst;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= StIdle;
          ts_reset_q  <= 1'b1;
          busy_q      <= 1'b0;
          avg_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEMPSENS_AVG_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 timeout_q;
  logic                 burst_clear;

  // A new burst begins from IDLE on start or from OUT on a continuous handshake.
  always_comb begin
    burst_clear = 1'b0;
    tmo_hit     = 1'b0;
    burst_clear = (state_q == StIdle && i_start) ||
                  (state_q == StOut && i_avg_ready && i_continuous);
    tmo_hit     = (state_q == StConv) && (&tmo_cnt_q) && !i_ts_done;
  end

  // The conversion timeout counter restarts on every CONV entry. The flag is sticky per burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StRst) begin
        tmo_cnt_q <= '0;
      end else if (state_q == StConv && !take) begin
        tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
      end
      if (burst_clear) begin
        timeout_q <= 1'b0;
      end else if (tmo_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_ts_reset  = ts_reset_q;
  assign o_busy      = busy_q;
  assign o_avg       = avg_q;
  assign o_avg_valid = avg_valid_q;

endmodule
